maverik_seq: RTL and testbench
==============================

Name: maverik_seq

Overview:
- Multi-cycle control sequencer for the 8-bit accumulator core: program counter (PC), synchronous program memory, ALU, accumulator, jump adder.
- Instruction format: [7:5] opcode, [4:0] immediate.
- Replaces the free-running one-instruction-per-clock PC update with a FETCH/DECODE/EXEC/WB state machine. Holds the instruction register and drives all datapath write strobes.
- Adds a debug layer: run/halt/single-step, PC breakpoint, retired-instruction counter.

Parameters:
- JMP_OPCODE, 3'b011, opcode selecting the relative jump (PC + zero-extended imm).
- HALT_OPCODE, 3'b111, opcode treated as HALT when HALT_EN=1.
- HALT_EN, 1, enable HALT opcode decode; when 0, HALT_OPCODE is an ordinary ALU op.
- START_RUNNING, 1, 1: leave reset into FETCH; 0: leave reset into HALTED.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  8  program memory data_out; valid the cycle after the address is presented
- pc_in  in  8  current datapath PC (memory address)
- run_req  in  1  level; leave HALTED and run continuously
- step_req  in  1  level; leave HALTED and execute exactly one instruction
- halt_req  in  1  level; stop at the next instruction boundary
- bp_en  in  1  breakpoint enable
- bp_addr  in  8  breakpoint PC
- ir  out  8  instruction register to ALU and jump adder
- pc_we  out  1  load PC
- pc_sel  out  1  0 = PC+1, 1 = jump target
- acc_we  out  1  load accumulator from ALU
- state  out  3  encoding: HALTED=0, FETCH=1, DECODE=2, EXEC=3, WB=4
- halted  out  1  state==HALTED
- step_done  out  1  one-cycle pulse when a single step completes
- bp_hit  out  1  one-cycle pulse when the breakpoint stops execution
- instr_count  out  16  retired instruction counter

Behaviour:
- Reset (async, immediate):
  - state = FETCH if START_RUNNING else HALTED.
  - ir=0, instr_count=0, step_done=0, bp_hit=0, step_mode=0, bp_armed=0.
  - pc_we, acc_we and pc_sel read 0.
- Strobes are Moore outputs decoded from registered state and ir. They are never asserted outside WB.
- FETCH (1 cycle): memory reads pc_in. No strobes.
  - Breakpoint: if bp_en && bp_armed && pc_in==bp_addr, next state is HALTED, bp_hit pulses one cycle later (registered), bp_armed clears. The instruction at bp_addr is not executed.
  - Otherwise next state is DECODE.
- DECODE (1 cycle): ir <= instr. Next state EXEC.
- EXEC (1 cycle): ALU and jump adder settle from ir. Next state WB.
- WB (1 cycle):
  - pc_we=1.
  - pc_sel=1 iff ir[7:5]==JMP_OPCODE.
  - acc_we=1 iff opcode is neither JMP nor an enabled HALT.
  - instr_count increments (wraps 16'hFFFF -> 0). bp_armed sets.
  - Next state, in priority order:
    - enabled HALT opcode -> HALTED (PC still advances by 1);
    - step_mode -> HALTED, step_done pulses next cycle, step_mode clears;
    - halt_req -> HALTED;
    - otherwise FETCH.
- HALTED: no strobes, ir holds.
  - Next state, in priority order:
    - halt_req -> stay;
    - step_req -> FETCH with step_mode=1;
    - run_req -> FETCH with step_mode=0.
  - Leaving HALTED clears bp_armed, so resuming at a breakpoint address executes that instruction.
- Latency: 4 cycles per instruction; first WB occurs 4 cycles after leaving reset or HALTED.
- halt_req asserted mid-instruction: the current instruction completes through WB, then the sequencer stops. It never aborts between FETCH and WB.
- Simultaneous step_req and run_req in HALTED: step wins.
- step_req held high: one instruction per HALTED visit. Each step costs 5 cycles including 1 HALTED cycle.
- Reset mid-instruction: the instruction is discarded, no strobe is issued, the counter zeroes.
- PC wrap (0xFF -> 0x00) belongs to the datapath adders; the sequencer is unaffected.

Test Plan:
- Reset with START_RUNNING=1; program ALU op, ALU op, JMP +3 at 0..2 -> WB at cycles 4, 8, 12; acc_we=1,1,0; pc_sel=0,0,1; instr_count=3 after cycle 12.
- HALT_EN=1; HALT at address 5 -> state=HALTED after that WB, pc_we pulsed once, acc_we never asserted, instr_count incremented; run_req later resumes at address 6.
- START_RUNNING=0; hold step_req=1 for 20 cycles -> exactly 4 step_done pulses, 5 cycles apart, instr_count=4.
- bp_en=1, bp_addr=8'h04, running from 0 -> halts after 4 retirements with bp_hit pulse and ir still holding the instruction at 0x03. run_req then executes 0x04 without re-triggering; a later loop back to 0x04 triggers bp_hit again.
- halt_req pulsed during DECODE -> WB still occurs with correct strobes, then HALTED; halt_req asserted together with run_req in HALTED -> remains HALTED.
- Assert rst during EXEC -> state resets immediately, no pc_we/acc_we that cycle, instr_count=0, ir=0.

Source files
------------

// File: rtl/maverik_seq.sv
// maverik_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the
// 8-bit accumulator core, with run/halt/step and a PC breakpoint.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   instr           program memory data (one cycle after address)
//   pc_in           current datapath PC / memory address
//   run_req         level: leave HALTED and run continuously
//   step_req        level: leave HALTED for exactly one instruction
//   halt_req        level: stop at the next instruction boundary
//   bp_en, bp_addr  breakpoint enable and address
//   ir              instruction register
//   pc_we, pc_sel   PC load strobe and source (1 = jump target)
//   acc_we          accumulator load strobe
//   state           HALTED=0 FETCH=1 DECODE=2 EXEC=3 WB=4
//   halted          state is HALTED
//   step_done       pulse after a single step completes
//   bp_hit          pulse when the breakpoint stops execution
//   instr_count     retired instruction counter (wraps)
module maverik_seq #(
   parameter logic [2:0] JMP_OPCODE    = 3'b011,
   parameter logic [2:0] HALT_OPCODE   = 3'b111,
   parameter bit         HALT_EN       = 1'b1,
   parameter bit         START_RUNNING = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  instr,
   input  logic [7:0]  pc_in,
   input  logic        run_req,
   input  logic        step_req,
   input  logic        halt_req,
   input  logic        bp_en,
   input  logic [7:0]  bp_addr,
   output logic [7:0]  ir,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        acc_we,
   output logic [2:0]  state,
   output logic        halted,
   output logic        step_done,
   output logic        bp_hit,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_HALTED = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam state_t RESET_STATE = START_RUNNING ? S_FETCH : S_HALTED;

   state_t      state_q, state_d;
   logic [7:0]  ir_q;
   logic [15:0] cnt_q;
   logic        step_done_q, step_done_d;
   logic        bp_hit_q, bp_hit_d;
   logic        step_mode_q, step_mode_d;
   logic        bp_armed_q, bp_armed_d;
   logic        halt_pend_q, halt_pend_d;
   logic        ir_load;
   logic        retire;
   logic        is_jmp;
   logic        is_halt;
   logic        in_wb;

   assign is_jmp  = (ir_q[7:5] == JMP_OPCODE);
   assign is_halt = HALT_EN && (ir_q[7:5] == HALT_OPCODE);
   assign in_wb   = (state_q == S_WB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RESET_STATE;
         ir_q        <= 8'h00;
         cnt_q       <= 16'h0000;
         step_done_q <= 1'b0;
         bp_hit_q    <= 1'b0;
         step_mode_q <= 1'b0;
         bp_armed_q  <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_done_q <= step_done_d;
         bp_hit_q    <= bp_hit_d;
         step_mode_q <= step_mode_d;
         bp_armed_q  <= bp_armed_d;
         halt_pend_q <= halt_pend_d;
         if (ir_load) ir_q <= instr;
         if (retire)  cnt_q <= cnt_q + 16'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_mode_d = step_mode_q;
      bp_armed_d  = bp_armed_q;
      // a short halt_req pulse mid-instruction is remembered until WB
      halt_pend_d = halt_pend_q | halt_req;
      step_done_d = 1'b0;
      bp_hit_d    = 1'b0;
      ir_load     = 1'b0;
      retire      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (bp_en && bp_armed_q && (pc_in == bp_addr)) begin
               state_d     = S_HALTED;
               bp_hit_d    = 1'b1;
               bp_armed_d  = 1'b0;
               halt_pend_d = 1'b0;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            ir_load = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: state_d = S_WB;
         S_WB: begin
            retire     = 1'b1;
            bp_armed_d = 1'b1;
            if (is_halt) begin
               state_d     = S_HALTED;
               halt_pend_d = 1'b0;
            end else if (step_mode_q) begin
               state_d     = S_HALTED;
               step_done_d = 1'b1;
               step_mode_d = 1'b0;
               halt_pend_d = 1'b0;
            end else if (halt_req || halt_pend_q) begin
               state_d     = S_HALTED;
               halt_pend_d = 1'b0;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            halt_pend_d = 1'b0;
            // disarm so resuming on the breakpoint address executes it
            if (halt_req) begin
               state_d = S_HALTED;
            end else if (step_req) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b1;
               bp_armed_d  = 1'b0;
            end else if (run_req) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b0;
               bp_armed_d  = 1'b0;
            end
         end
         default: state_d = S_HALTED;
      endcase
   end

   assign ir          = ir_q;
   assign pc_we       = in_wb;
   assign pc_sel      = in_wb && is_jmp;
   assign acc_we      = in_wb && !is_jmp && !is_halt;
   assign state       = state_q;
   assign halted      = (state_q == S_HALTED);
   assign step_done   = step_done_q;
   assign bp_hit      = bp_hit_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_maverik_seq.sv
// tb_maverik_seq: directed bench for maverik_seq with a small PC and
// synchronous program memory model around two instances.
module tb_maverik_seq;

   logic clk, rst;
   logic run_req, step_req, halt_req, bp_en;
   logic [7:0] bp_addr;
   logic [7:0] mem [256];

   logic [7:0]  instr_r, pc_r, ir_r;
   logic        pc_we_r, pc_sel_r, acc_we_r, halted_r, sd_r, bp_r;
   logic [2:0]  state_r;
   logic [15:0] cnt_r;

   logic [7:0]  instr_s, pc_s, ir_s;
   logic        pc_we_s, pc_sel_s, acc_we_s, halted_s, sd_s, bp_s;
   logic [2:0]  state_s;
   logic [15:0] cnt_s;

   int vecs = 0;
   int errs = 0;

   maverik_seq #(.START_RUNNING(1'b1)) u_run (
      .clk(clk), .rst(rst), .instr(instr_r), .pc_in(pc_r),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .ir(ir_r), .pc_we(pc_we_r),
      .pc_sel(pc_sel_r), .acc_we(acc_we_r), .state(state_r),
      .halted(halted_r), .step_done(sd_r), .bp_hit(bp_r),
      .instr_count(cnt_r)
   );

   maverik_seq #(.START_RUNNING(1'b0)) u_stop (
      .clk(clk), .rst(rst), .instr(instr_s), .pc_in(pc_s),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .ir(ir_s), .pc_we(pc_we_s),
      .pc_sel(pc_sel_s), .acc_we(acc_we_s), .state(state_s),
      .halted(halted_s), .step_done(sd_s), .bp_hit(bp_s),
      .instr_count(cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_r <= 8'h00;
      else if (pc_we_r) pc_r <= pc_sel_r ? pc_r + {3'b000, ir_r[4:0]} : pc_r + 8'd1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_s <= 8'h00;
      else if (pc_we_s) pc_s <= pc_sel_s ? pc_s + {3'b000, ir_s[4:0]} : pc_s + 8'd1;
   end
   always_ff @(posedge clk) begin
      instr_r <= mem[pc_r];
      instr_s <= mem[pc_s];
   end

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   // leaves rst released at a falling edge: that half-cycle is cycle 1
   task automatic do_reset();
      run_req = 0; step_req = 0; halt_req = 0;
      @(negedge clk); rst = 1;
      @(negedge clk); @(negedge clk); rst = 0;
   endtask

   task automatic test_reset();
      fill(8'h01);
      do_reset();
      vecs++; if (state_r !== 3'd1) begin errs++; $display("FAIL rst_state got %0d want 1", state_r); end
      vecs++; if (ir_r !== 8'h00) begin errs++; $display("FAIL rst_ir got %h want 00", ir_r); end
      vecs++; if (cnt_r !== 16'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", cnt_r); end
      vecs++; if ({pc_we_r, acc_we_r, pc_sel_r} !== 3'b000) begin errs++; $display("FAIL rst_strobes got %b want 000", {pc_we_r, acc_we_r, pc_sel_r}); end
      vecs++; if ({sd_r, bp_r, halted_r} !== 3'b000) begin errs++; $display("FAIL rst_pulses got %b want 000", {sd_r, bp_r, halted_r}); end
      vecs++; if (state_s !== 3'd0 || halted_s !== 1'b1) begin errs++; $display("FAIL rst_stop_state got %0d/%b want 0/1", state_s, halted_s); end
   endtask

   task automatic test_sequence();
      fill(8'h01);
      mem[1] = 8'h22; mem[2] = 8'h63; mem[5] = 8'hE0; mem[6] = 8'h45;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge clk);
         if (c % 4 == 0) begin
            vecs++; if (pc_we_r !== 1'b1) begin errs++; $display("FAIL seq_pc_we c%0d got %b want 1", c, pc_we_r); end
            vecs++; if (acc_we_r !== (c != 12)) begin errs++; $display("FAIL seq_acc_we c%0d got %b want %b", c, acc_we_r, c != 12); end
            vecs++; if (pc_sel_r !== (c == 12)) begin errs++; $display("FAIL seq_pc_sel c%0d got %b want %b", c, pc_sel_r, c == 12); end
         end else begin
            vecs++; if ({pc_we_r, acc_we_r} !== 2'b00) begin errs++; $display("FAIL seq_idle c%0d got %b want 00", c, {pc_we_r, acc_we_r}); end
         end
      end
      @(negedge clk);
      vecs++; if (cnt_r !== 16'd3) begin errs++; $display("FAIL seq_cnt got %0d want 3", cnt_r); end
      vecs++; if (pc_r !== 8'h05) begin errs++; $display("FAIL seq_pc got %h want 05", pc_r); end
   endtask

   task automatic test_halt_op();
      int nwe = 0, nacc = 0;
      for (int c = 13; c <= 16; c++) begin
         if (c > 13) @(negedge clk);
         nwe += int'(pc_we_r); nacc += int'(acc_we_r);
      end
      @(negedge clk);
      nwe += int'(pc_we_r); nacc += int'(acc_we_r);
      vecs++; if (halted_r !== 1'b1) begin errs++; $display("FAIL hop_halted got %b want 1", halted_r); end
      vecs++; if (nwe != 1 || nacc != 0) begin errs++; $display("FAIL hop_strobes got we=%0d acc=%0d want 1/0", nwe, nacc); end
      vecs++; if (cnt_r !== 16'd4) begin errs++; $display("FAIL hop_cnt got %0d want 4", cnt_r); end
      vecs++; if (pc_r !== 8'h06) begin errs++; $display("FAIL hop_pc got %h want 06", pc_r); end
      repeat (3) @(negedge clk);
      vecs++; if (state_r !== 3'd0) begin errs++; $display("FAIL hop_stay got %0d want 0", state_r); end
      run_req = 1;
      @(negedge clk); run_req = 0;
      vecs++; if (state_r !== 3'd1 || pc_r !== 8'h06) begin errs++; $display("FAIL hop_resume got st=%0d pc=%h want 1/06", state_r, pc_r); end
   endtask

   task automatic test_halt_req();
      @(negedge clk);
      vecs++; if (state_r !== 3'd2) begin errs++; $display("FAIL hreq_decode got %0d want 2", state_r); end
      halt_req = 1;
      @(negedge clk); halt_req = 0;
      @(negedge clk);
      vecs++; if ({pc_we_r, acc_we_r, pc_sel_r} !== 3'b110) begin errs++; $display("FAIL hreq_wb got %b want 110", {pc_we_r, acc_we_r, pc_sel_r}); end
      vecs++; if (ir_r !== 8'h45) begin errs++; $display("FAIL hreq_ir got %h want 45", ir_r); end
      @(negedge clk);
      vecs++; if (state_r !== 3'd0 || cnt_r !== 16'd5) begin errs++; $display("FAIL hreq_stop got st=%0d cnt=%0d want 0/5", state_r, cnt_r); end
      halt_req = 1; run_req = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vecs++; if (state_r !== 3'd0) begin errs++; $display("FAIL hreq_hold%0d got %0d want 0", i, state_r); end
      end
      halt_req = 0;
      @(negedge clk); run_req = 0;
      vecs++; if (state_r !== 3'd1) begin errs++; $display("FAIL hreq_release got %0d want 1", state_r); end
   endtask

   task automatic test_step();
      int pulses = 0, last = 0, first = 0;
      fill(8'h01);
      do_reset();
      step_req = 1;
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) @(negedge clk);
         if (sd_s) begin
            pulses++;
            if (last != 0) begin
               vecs++; if (c - last != 5) begin errs++; $display("FAIL step_gap got %0d want 5", c - last); end
            end else first = c;
            last = c;
         end
         if (c == 20) step_req = 0;
      end
      vecs++; if (pulses != 4) begin errs++; $display("FAIL step_pulses got %0d want 4", pulses); end
      vecs++; if (first != 6) begin errs++; $display("FAIL step_first got %0d want 6", first); end
      vecs++; if (cnt_s !== 16'd4) begin errs++; $display("FAIL step_cnt got %0d want 4", cnt_s); end
      vecs++; if (state_s !== 3'd0) begin errs++; $display("FAIL step_final got %0d want 0", state_s); end
   endtask

   task automatic test_breakpoint();
      int n;
      fill(8'h01);
      mem[3] = 8'h23; mem[4] = 8'h44;
      bp_en = 1; bp_addr = 8'h04;
      do_reset();
      n = 0;
      while (!halted_r && n < 60) begin @(negedge clk); n++; end
      vecs++; if (!halted_r) begin errs++; $display("FAIL bp_wait1 timeout state=%0d", state_r); end
      vecs++; if (bp_r !== 1'b1) begin errs++; $display("FAIL bp_hit1 got %b want 1", bp_r); end
      vecs++; if (cnt_r !== 16'd4 || ir_r !== 8'h23 || pc_r !== 8'h04) begin errs++; $display("FAIL bp_ctx got cnt=%0d ir=%h pc=%h want 4/23/04", cnt_r, ir_r, pc_r); end
      @(negedge clk);
      vecs++; if (bp_r !== 1'b0) begin errs++; $display("FAIL bp_pulse got %b want 0", bp_r); end
      run_req = 1;
      @(negedge clk); run_req = 0;
      n = 0;
      while (cnt_r != 16'd5 && n < 10) begin @(negedge clk); n++; end
      vecs++; if (cnt_r !== 16'd5 || ir_r !== 8'h44 || halted_r !== 1'b0) begin errs++; $display("FAIL bp_resume got cnt=%0d ir=%h h=%b want 5/44/0", cnt_r, ir_r, halted_r); end
      n = 0;
      while (!bp_r && n < 1500) begin @(negedge clk); n++; end
      vecs++; if (bp_r !== 1'b1) begin errs++; $display("FAIL bp_wait2 timeout cnt=%0d", cnt_r); end
      vecs++; if (cnt_r !== 16'd260 || pc_r !== 8'h04 || ir_r !== 8'h23) begin errs++; $display("FAIL bp_hit2 got cnt=%0d pc=%h ir=%h want 260/04/23", cnt_r, pc_r, ir_r); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      bp_en = 0;
      run_req = 1;
      @(negedge clk); run_req = 0;
      while (state_r != 3'd3 && n < 10) begin @(negedge clk); n++; end
      vecs++; if (state_r !== 3'd3) begin errs++; $display("FAIL rmid_wait got %0d want 3", state_r); end
      rst = 1;
      #1;
      vecs++; if (state_r !== 3'd1) begin errs++; $display("FAIL rmid_state got %0d want 1", state_r); end
      vecs++; if ({pc_we_r, acc_we_r} !== 2'b00) begin errs++; $display("FAIL rmid_strobes got %b want 00", {pc_we_r, acc_we_r}); end
      vecs++; if (cnt_r !== 16'd0 || ir_r !== 8'h00) begin errs++; $display("FAIL rmid_regs got cnt=%0d ir=%h want 0/00", cnt_r, ir_r); end
      @(negedge clk);
      vecs++; if (pc_we_r !== 1'b0) begin errs++; $display("FAIL rmid_hold got %b want 0", pc_we_r); end
      rst = 0;
   endtask

   initial begin
      rst = 1; run_req = 0; step_req = 0; halt_req = 0;
      bp_en = 0; bp_addr = 8'h00;
      fill(8'h01);
      test_reset();
      test_sequence();
      test_halt_op();
      test_halt_req();
      test_step();
      test_breakpoint();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
